// File: rtl/uart_rx_cfg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_rx_cfg
// Description : Oversampling UART receiver with configurable data width,
//               parity mode and stop-bit count; flags parity/framing errors.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_cfg #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       b_tick,
    output logic [7:0] rx_data,
    output logic       rx_done,
    output logic       parity_err,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam int              C_TW        = $clog2(OVERSAMPLE);
    localparam logic [C_TW-1:0] C_TICK_MID  = C_TW'(OVERSAMPLE / 2 - 1);
    localparam logic [C_TW-1:0] C_TICK_END  = C_TW'(OVERSAMPLE - 1);
    localparam logic [2:0]      C_BIT_LAST  = 3'(DATA_BITS - 1);
    localparam logic            C_STOP_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;

    logic                   r_sync1;
    logic                   r_sync2;
    logic                   r_rx_prev;
    logic [C_TW-1:0]        r_tick_cnt;
    logic [2:0]             r_bit_cnt;
    logic                   r_stop_cnt;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_par_err;
    logic                   r_frm_err;
    logic [7:0]             r_rx_data;
    logic                   r_rx_done;
    logic                   r_parity_err;
    logic                   r_frame_err;
    logic                   r_busy;

    logic                   w_fall;
    logic                   w_at_mid;
    logic                   w_at_end;
    logic                   w_par_xor;
    logic                   w_par_bad;
    logic [7:0]             w_data_ext;

    logic                   w_tick_clr;
    logic                   w_frame_start;
    logic                   w_shift;
    logic                   w_par_chk;
    logic                   w_stop_smp;
    logic                   w_done;

    assign w_fall    = r_rx_prev & ~r_sync2;
    assign w_at_mid  = b_tick && (r_tick_cnt == C_TICK_MID);
    assign w_at_end  = b_tick && (r_tick_cnt == C_TICK_END);
    assign w_par_xor = (^r_shift) ^ r_sync2;
    assign w_par_bad = (PARITY == 2) ? w_par_xor : ~w_par_xor;

    always_comb begin
        w_data_ext                = '0;
        w_data_ext[DATA_BITS-1:0] = r_shift;
    end

    // Synchroniser and edge-detect history idle high so reset never looks like a start edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync1   <= rx;
            r_sync2   <= r_sync1;
            r_rx_prev <= r_sync2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_tick_clr    = 1'b0;
        w_frame_start = 1'b0;
        w_shift       = 1'b0;
        w_par_chk     = 1'b0;
        w_stop_smp    = 1'b0;
        w_done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_fall) begin
                    w_state_next = S_START;
                    w_tick_clr   = 1'b1;
                end
            end
            S_START: begin
                if (w_at_mid) begin
                    if (r_sync2) begin
                        w_state_next = S_IDLE;
                    end else begin
                        w_state_next  = S_DATA;
                        w_tick_clr    = 1'b1;
                        w_frame_start = 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (w_at_end) begin
                    w_shift    = 1'b1;
                    w_tick_clr = 1'b1;
                    if (r_bit_cnt == C_BIT_LAST) begin
                        w_state_next = (PARITY != 0) ? S_PARITY : S_STOP;
                    end
                end
            end
            S_PARITY: begin
                if (w_at_end) begin
                    w_par_chk    = 1'b1;
                    w_tick_clr   = 1'b1;
                    w_state_next = S_STOP;
                end
            end
            S_STOP: begin
                if (w_at_end) begin
                    w_stop_smp = 1'b1;
                    w_tick_clr = 1'b1;
                    if (r_stop_cnt == C_STOP_LAST) begin
                        w_done       = 1'b1;
                        w_state_next = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
            r_shift    <= '0;
            r_par_err  <= 1'b0;
            r_frm_err  <= 1'b0;
        end else begin
            if (w_tick_clr) begin
                r_tick_cnt <= '0;
            end else if (b_tick && (r_state != S_IDLE)) begin
                r_tick_cnt <= r_tick_cnt + 1'b1;
            end

            if (w_frame_start) begin
                r_bit_cnt  <= '0;
                r_stop_cnt <= 1'b0;
                r_par_err  <= 1'b0;
                r_frm_err  <= 1'b0;
            end else begin
                if (w_shift) begin
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                end
                if (w_stop_smp) begin
                    r_stop_cnt <= r_stop_cnt + 1'b1;
                    if (!r_sync2) begin
                        r_frm_err <= 1'b1;
                    end
                end
                if (w_par_chk) begin
                    r_par_err <= w_par_bad;
                end
            end

            // LSB arrives first, so each new bit enters at the top and walks down
            if (w_shift) begin
                r_shift <= {r_sync2, r_shift[DATA_BITS-1:1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_data    <= '0;
            r_rx_done    <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_rx_done <= w_done;
            r_busy    <= (w_state_next != S_IDLE);
            if (w_done) begin
                r_rx_data    <= w_data_ext;
                r_parity_err <= r_par_err;
                r_frame_err  <= r_frm_err | ~r_sync2;
            end
        end
    end

    assign rx_data    = r_rx_data;
    assign rx_done    = r_rx_done;
    assign parity_err = r_parity_err;
    assign frame_err  = r_frame_err;
    assign rx_busy    = r_busy;

endmodule
`default_nettype wire
